spi_avalon_frame_controller: RTL and testbench

//  Sequences the byte stream from the SPI receive buffer into command frames and

---
 rtl/spi_avalon_pkg.sv | 19 +
 rtl/spi_edge_sync.sv | 30 +++
 rtl/spi_avalon_frame_controller.sv | 192 +++++++++++++++++++
 tb/tb_spi_avalon_frame_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_avalon_pkg.sv
// Shared state encoding and default opcodes for the SPI-to-Avalon frame controller.
package spi_avalon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_AV_WRITE,
        ST_AV_READ,
        ST_RDATA,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] OP_WRITE_DEFAULT   = 8'h01;
    localparam logic [7:0] OP_READ_DEFAULT    = 8'h02;
    localparam int         DATA_BYTES_DEFAULT = 8;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for a slow SPI-domain level, with single-cycle
// rising/falling edge pulses in the clock domain.
module spi_edge_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg <= {STAGES{INIT}};
            prev_reg <= INIT;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_avalon_frame_controller.sv
// Turns SPI receive bytes into opcode/address/data frames and runs them as
// Avalon-MM master reads and writes; read data is streamed back byte by byte.
module spi_avalon_frame_controller
    import spi_avalon_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter int         DATA_BYTES  = DATA_BYTES_DEFAULT,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] OP_WRITE    = OP_WRITE_DEFAULT,
    parameter logic [7:0] OP_READ     = OP_READ_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              io_InputBuffer,
    input  logic                    io_BufferChanged,
    input  logic                    io_ChipSelect,
    output logic [ADDR_W-1:0]       io_Avalon_address,
    output logic                    io_Avalon_read,
    output logic                    io_Avalon_write,
    output logic [8*DATA_BYTES-1:0] io_Avalon_writedata,
    input  logic [8*DATA_BYTES-1:0] io_Avalon_readdata,
    input  logic                    io_Avalon_waitrequest,
    output logic [7:0]              io_TxByte,
    output logic                    io_Busy,
    output logic                    io_Error
);

    localparam int               DW        = 8 * DATA_BYTES;
    localparam int               CNT_W     = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              is_write_reg, is_write_next;
    logic              cs_abort_reg, cs_abort_next;
    logic              error_reg, error_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DW-1:0]     wdata_reg, wdata_next;
    logic [DW-1:0]     tx_reg, tx_next;

    logic cs_assert, cs_deassert, byte_event, changed_fall_unused;

    // CS idles high, so its synchroniser resets to 1 to avoid a false deassert edge.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clock (clock),
        .reset (reset),
        .din   (io_ChipSelect),
        .rise  (cs_deassert),
        .fall  (cs_assert)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_changed_sync (
        .clock (clock),
        .reset (reset),
        .din   (io_BufferChanged),
        .rise  (byte_event),
        .fall  (changed_fall_unused)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            is_write_reg <= 1'b0;
            cs_abort_reg <= 1'b0;
            error_reg    <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            tx_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            is_write_reg <= is_write_next;
            cs_abort_reg <= cs_abort_next;
            error_reg    <= error_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            tx_reg       <= tx_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        is_write_next = is_write_reg;
        cs_abort_next = cs_abort_reg;
        error_next    = error_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        tx_next       = tx_reg;

        // CS deassert is tested before the byte event so a coincident byte is dropped.
        case (state_reg)
            ST_IDLE: begin
                if (cs_assert) begin
                    state_next    = ST_CMD;
                    error_next    = 1'b0;
                    cnt_next      = '0;
                    cs_abort_next = 1'b0;
                    tx_next       = '0;
                end
            end
            ST_CMD: begin
                if (cs_deassert) begin
                    state_next = ST_IDLE;
                end else if (byte_event) begin
                    if (io_InputBuffer == OP_WRITE) begin
                        is_write_next = 1'b1;
                        state_next    = ST_ADDR;
                    end else if (io_InputBuffer == OP_READ) begin
                        is_write_next = 1'b0;
                        state_next    = ST_ADDR;
                    end else begin
                        error_next = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_ADDR: begin
                if (cs_deassert) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (byte_event) begin
                    addr_next  = io_InputBuffer[ADDR_W-1:0];
                    cnt_next   = '0;
                    state_next = is_write_reg ? ST_WDATA : ST_AV_READ;
                end
            end
            ST_WDATA: begin
                if (cs_deassert) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (byte_event) begin
                    wdata_next = {wdata_reg[DW-9:0], io_InputBuffer};
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BYTE) state_next = ST_AV_WRITE;
                end
            end
            ST_AV_WRITE: begin
                if (!io_Avalon_waitrequest) begin
                    if (cs_abort_reg || cs_deassert) begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (cs_deassert) begin
                    cs_abort_next = 1'b1;
                end
            end
            ST_AV_READ: begin
                if (!io_Avalon_waitrequest) begin
                    if (cs_abort_reg || cs_deassert) begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        tx_next    = io_Avalon_readdata;
                        cnt_next   = '0;
                        state_next = ST_RDATA;
                    end
                end else if (cs_deassert) begin
                    cs_abort_next = 1'b1;
                end
            end
            ST_RDATA: begin
                if (cs_deassert) begin
                    error_next = 1'b1;
                    tx_next    = '0;
                    state_next = ST_IDLE;
                end else if (byte_event) begin
                    // After DATA_BYTES shifts the register is all zeros, so TxByte reads 00.
                    tx_next  = tx_reg << 8;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BYTE) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cs_deassert) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign io_Avalon_address   = addr_reg;
    assign io_Avalon_read      = (state_reg == ST_AV_READ);
    assign io_Avalon_write     = (state_reg == ST_AV_WRITE);
    assign io_Avalon_writedata = wdata_reg;
    assign io_TxByte           = tx_reg[DW-1 -: 8];
    assign io_Busy             = (state_reg != ST_IDLE);
    assign io_Error            = error_reg;

endmodule

// File: tb/tb_spi_avalon_frame_controller.sv
// Randomized scoreboard bench: frames are modelled as byte lists and the expected
// Avalon transactions, TX bytes and end-of-frame status are queued for monitors.
`timescale 1ns/1ps
module tb_spi_avalon_frame_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  io_InputBuffer;
    logic        io_BufferChanged;
    logic        io_ChipSelect = 1'b1;
    logic [6:0]  io_Avalon_address;
    logic        io_Avalon_read;
    logic        io_Avalon_write;
    logic [63:0] io_Avalon_writedata;
    logic [63:0] io_Avalon_readdata;
    logic        io_Avalon_waitrequest;
    logic [7:0]  io_TxByte;
    logic        io_Busy;
    logic        io_Error;

    always #5 clock = ~clock;

    spi_avalon_frame_controller dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_InputBuffer        (io_InputBuffer),
        .io_BufferChanged      (io_BufferChanged),
        .io_ChipSelect         (io_ChipSelect),
        .io_Avalon_address     (io_Avalon_address),
        .io_Avalon_read        (io_Avalon_read),
        .io_Avalon_write       (io_Avalon_write),
        .io_Avalon_writedata   (io_Avalon_writedata),
        .io_Avalon_readdata    (io_Avalon_readdata),
        .io_Avalon_waitrequest (io_Avalon_waitrequest),
        .io_TxByte             (io_TxByte),
        .io_Busy               (io_Busy),
        .io_Error              (io_Error)
    );

    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [63:0] data;
        int          stall;
    } av_exp_t;

    av_exp_t    exp_av[$];
    bit         exp_err[$];
    logic [7:0] exp_tx[$];
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        io_InputBuffer   = b;
        io_BufferChanged = 1'b1;
        repeat (4) @(negedge clock);
        io_BufferChanged = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_low();
        io_ChipSelect = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic end_frame(input bit e);
        exp_err.push_back(e);
        io_ChipSelect = 1'b1;
        repeat (40) @(negedge clock);
    endtask

    // n_after_op: bytes sent after the opcode (address + data); 9 is a full frame.
    task automatic write_frame(input logic [7:0] addr_b, input logic [63:0] data,
                               input int stall, input int n_after_op, input bit cs_in_av);
        bit full;
        full = (n_after_op >= 9);
        $display("frame write addr=%02h data=%016h stall=%0d bytes=%0d cs_in_av=%0d",
                 addr_b, data, stall, n_after_op, cs_in_av);
        cs_low();
        if (full) exp_av.push_back('{1'b1, addr_b[6:0], data, stall});
        send_byte(8'h01);
        for (int i = 0; i < n_after_op && i < 9; i++)
            send_byte(i == 0 ? addr_b : data[63-8*(i-1) -: 8]);
        if (!(full && cs_in_av)) repeat (8) @(negedge clock);
        end_frame(!full || cs_in_av);
    endtask

    task automatic read_frame(input logic [7:0] addr_b, input logic [63:0] rdata,
                              input int stall, input int n_dummy, input bit with_addr);
        $display("frame read addr=%02h rdata=%016h stall=%0d dummies=%0d with_addr=%0d",
                 addr_b, rdata, stall, n_dummy, with_addr);
        cs_low();
        if (!with_addr) begin
            send_byte(8'h02);
            end_frame(1'b1);
        end else begin
            io_Avalon_readdata = rdata;
            exp_av.push_back('{1'b0, addr_b[6:0], 64'h0, stall});
            send_byte(8'h02);
            send_byte(addr_b);
            repeat (8) @(negedge clock);
            for (int i = 0; i < n_dummy; i++) exp_tx.push_back(rdata[63-8*i -: 8]);
            if (n_dummy >= 8) exp_tx.push_back(8'h00);
            for (int i = 0; i < n_dummy; i++) send_byte(8'($urandom));
            end_frame(n_dummy < 8);
        end
    endtask

    task automatic bad_frame(input logic [7:0] op, input int extras);
        $display("frame bad opcode=%02h extras=%0d", op, extras);
        cs_low();
        send_byte(op);
        for (int i = 0; i < extras; i++) send_byte(8'($urandom));
        repeat (4) @(negedge clock);
        end_frame(1'b1);
    endtask

    task automatic empty_frame();
        $display("frame empty");
        cs_low();
        end_frame(1'b0);
    endtask

    // ---------------- monitors ----------------
    // Avalon slave model plus transaction scoreboard.
    initial begin : av_monitor
        bit          active;
        int          held;
        int          stall;
        bit          stable;
        logic [6:0]  addr0;
        logic [63:0] data0;
        av_exp_t     e;
        active = 0; held = 0; stall = 0; stable = 1; addr0 = '0; data0 = '0;
        io_Avalon_waitrequest = 1'b1;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1 || !(io_Avalon_read || io_Avalon_write)) begin
                active = 0;
                io_Avalon_waitrequest = 1'b1;
            end else begin
                if (!active) begin
                    active = 1; held = 0; stable = 1;
                    addr0 = io_Avalon_address; data0 = io_Avalon_writedata;
                    stall = (exp_av.size() > 0) ? exp_av[0].stall : 0;
                end
                held++;
                if (io_Avalon_address !== addr0 || io_Avalon_writedata !== data0) stable = 0;
                if (held > stall) begin
                    io_Avalon_waitrequest = 1'b0;
                    active = 0;
                    if (exp_av.size() == 0) begin
                        check("unexpected_request", 64'({io_Avalon_read, io_Avalon_write}), 64'h0);
                    end else begin
                        e = exp_av.pop_front();
                        check("req_kind", 64'({io_Avalon_read, io_Avalon_write}),
                              e.is_wr ? 64'h1 : 64'h2);
                        check("req_addr", 64'(io_Avalon_address), 64'(e.addr));
                        if (e.is_wr) check("req_wdata", io_Avalon_writedata, e.data);
                        check("req_held_cycles", 64'(held), 64'(e.stall + 1));
                        check("req_stable", 64'(stable), 64'h1);
                        $display("avalon %s addr=%02h wdata=%016h held=%0d",
                                 e.is_wr ? "write" : "read", io_Avalon_address,
                                 io_Avalon_writedata, held);
                    end
                end else begin
                    io_Avalon_waitrequest = 1'b1;
                end
            end
        end
    end

    // The SPI shifter takes TxByte at the start of each byte.
    initial begin : tx_monitor
        forever begin
            @(posedge io_BufferChanged);
            if (exp_tx.size() > 0) check("tx_byte", 64'(io_TxByte), 64'(exp_tx.pop_front()));
        end
    end

    initial begin : cs_monitor
        bit e;
        int n;
        forever begin
            @(posedge io_ChipSelect);
            if (exp_tx.size() > 0) check("tx_byte_end", 64'(io_TxByte), 64'(exp_tx.pop_front()));
            if (exp_err.size() > 0) begin
                e = exp_err.pop_front();
                n = 0;
                while (io_Busy && n < 30) begin
                    @(negedge clock);
                    n++;
                end
                check("busy_after_cs", 64'(io_Busy), 64'h0);
                check("error_after_cs", 64'(io_Error), 64'(e));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int          kind;
        logic [63:0] d;
        logic [7:0]  op;
        reset              = 1'b0;
        io_ChipSelect      = 1'b1;
        io_BufferChanged   = 1'b0;
        io_InputBuffer     = 8'h00;
        io_Avalon_readdata = 64'h0;
        repeat (3) @(negedge clock);
        check("rst_read",      64'(io_Avalon_read), 64'h0);
        check("rst_write",     64'(io_Avalon_write), 64'h0);
        check("rst_address",   64'(io_Avalon_address), 64'h0);
        check("rst_writedata", io_Avalon_writedata, 64'h0);
        check("rst_txbyte",    64'(io_TxByte), 64'h0);
        check("rst_busy",      64'(io_Busy), 64'h0);
        check("rst_error",     64'(io_Error), 64'h0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        write_frame(8'h05, 64'h0102030405060708, 0, 9, 1'b0);
        write_frame(8'h05, 64'h0102030405060708, 3, 9, 1'b0);
        read_frame(8'h03, 64'hA1A2A3A4A5A6A7A8, 1, 8, 1'b1);
        bad_frame(8'h7A, 0);
        bad_frame(8'h80, 2);
        write_frame(8'h22, 64'h1122334455667788, 0, 5, 1'b0);
        empty_frame();

        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 5));
            d = {$urandom, $urandom};
            case (kind)
                0: write_frame(8'($urandom), d, int'($urandom_range(0, 3)), 9, 1'b0);
                1: read_frame(8'($urandom), d, int'($urandom_range(0, 3)), 8, 1'b1);
                2: begin
                    do op = 8'($urandom); while (op == 8'h01 || op == 8'h02);
                    bad_frame(op, int'($urandom_range(0, 3)));
                end
                3: write_frame(8'($urandom), d, 0, int'($urandom_range(0, 8)), 1'b0);
                4: empty_frame();
                default: read_frame(8'($urandom), d, int'($urandom_range(0, 3)),
                                    int'($urandom_range(0, 7)), 1'($urandom));
            endcase
        end

        // CS released while the slave is still stalling the write.
        write_frame(8'h6C, {$urandom, $urandom}, 12, 9, 1'b1);

        // Reset in the middle of a stalled write.
        $display("frame write interrupted by reset");
        d = 64'hDEADBEEF00C0FFEE;
        cs_low();
        exp_av.push_back('{1'b1, 7'h11, d, 30});
        send_byte(8'h01);
        send_byte(8'h11);
        for (int i = 0; i < 8; i++) send_byte(d[63-8*i -: 8]);
        check("write_before_reset", 64'(io_Avalon_write), 64'h1);
        #2 reset = 1'b0;
        #1;
        check("reset_write", 64'(io_Avalon_write), 64'h0);
        check("reset_read",  64'(io_Avalon_read), 64'h0);
        check("reset_busy",  64'(io_Busy), 64'h0);
        check("reset_error", 64'(io_Error), 64'h0);
        exp_av.delete();
        exp_err.push_back(1'b0);
        io_ChipSelect = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        check("pending_av",  64'(exp_av.size()), 64'h0);
        check("pending_tx",  64'(exp_tx.size()), 64'h0);
        check("pending_err", 64'(exp_err.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
